// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor d = a - b - bin behind a start/done handshake.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [WIDTH-1:0] res_sr_d;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             cell_diff;
  logic             cell_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             msb_borrow_q;
  logic             ovf_q;
`endif

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_diff),
    .bout (cell_bout)
  );

  // New difference bit enters at the MSB so the LSB-first result lands aligned.
  assign res_sr_d = {cell_diff, res_sr_q[WIDTH-1:1]};

  // FSM, operand/result shift registers, bit counter, borrow flop and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sr_q       <= {WIDTH{1'b0}};
      b_sr_q       <= {WIDTH{1'b0}};
      res_sr_q     <= {WIDTH{1'b0}};
      d_q          <= {WIDTH{1'b0}};
      cnt_q        <= {CW{1'b0}};
      borrow_q     <= 1'b0;
      bout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_borrow_q <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= bin;
            cnt_q    <= {CW{1'b0}};
            res_sr_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          res_sr_q <= res_sr_d;
          borrow_q <= cell_bout;
          cnt_q    <= cnt_q + CNT_ONE;
          busy_q   <= 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Last bit: publish the result together with the entry into DONE.
            d_q     <= res_sr_d;
            bout_q  <= cell_bout;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            msb_borrow_q <= borrow_q;
            ovf_q        <= borrow_q ^ cell_bout;
`endif
          end else begin
            done_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor (WIDTH=4), optional SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    int       due;
    logic [W-1:0] d;
    logic     bout;
    logic     ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   free_at = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_d = '0;
  logic         last_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input int due);
    exp_t e;
    int   diff, sa, sb, sdiff;
    diff   = int'(av) - int'(bv) - int'(bi);
    e.due  = due;
    e.bout = (diff < 0);
    e.d    = W'(diff & ((1 << W) - 1));
    sa     = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb     = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sdiff  = sa - sb - int'(bi);
    e.ovf  = (sdiff < -(1 << (W-1))) || (sdiff > (1 << (W-1)) - 1);
    return e;
  endfunction

  // Drive one cycle of inputs; the model accepts a start only when the unit is free.
  task automatic issue(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    int k;
    start = st;
    a     = av;
    b     = bv;
    bin   = bi;
    k     = cyc;
    @(posedge clk);
    if (st && k >= free_at) begin
      sb_q.push_back(model(av, bv, bi, k + W + 1));
      free_at = k + W + 2;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic pulse_reset();
    rst   = 1'b1;
    start = 1'b0;
    sb_q.delete();
    free_at   = 0;
    last_d    = '0;
    last_bout = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare busy every cycle, pop and compare on each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, (sb_q.size() > 0 && cyc >= sb_q[0].due - W) ? 1 : 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.due);
          check("d", d, e.d);
          check("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
          last_d    = e.d;
          last_bout = e.bout;
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
        flag("missing_done");
        void'(sb_q.pop_front());
      end else if (sb_q.size() == 0) begin
        check("d_hold", d, last_d);
        check("bout_hold", bout, last_bout);
      end
    end
  end

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic bi; } vec_t;
  vec_t vecs[7] = '{
    '{4'd9, 4'd3, 1'b0}, '{4'd3, 4'd9, 1'b0}, '{4'd0, 4'd0, 1'b1},
    '{4'd8, 4'd1, 1'b0}, '{4'd7, 4'd15, 1'b1}, '{4'd15, 4'd0, 1'b0},
    '{4'd0, 4'd15, 1'b1}
  };

  initial begin
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    foreach (vecs[i]) begin
      issue(1'b1, vecs[i].a, vecs[i].b, vecs[i].bi);
      idle_cycles(W + 2);
    end

    for (int i = 0; i < 200; i++)
      issue(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
    idle_cycles(W + 3);

    for (int i = 0; i < 36; i++)
      issue(1'b1, W'($urandom), W'($urandom), 1'($urandom));
    idle_cycles(W + 3);

    issue(1'b1, W'($urandom_range(8, 15)), W'($urandom_range(0, 7)), 1'b0);
    idle_cycles(W + 2);
    issue(1'b1, 4'd7, 4'd1, 1'b0);
    idle_cycles(1);
    pulse_reset();
    idle_cycles(W + 3);
    issue(1'b1, 4'd5, 4'd2, 1'b0);
    idle_cycles(W + 3);

    check("queue_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
